// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO: single-cycle MUL/MULT/MULTU/moves,
// and a 32-step restoring divider that stalls the pipeline until its result is ready.
module mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] mdu_a_i,
  input  logic [31:0] mdu_b_i,
  input  logic        mdu_flush_i,
  output logic [31:0] mdu_result_o,
  output logic        mdu_stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // state | meaning
  // IDLE  | no divide in flight; operands sampled on a DIV/DIVU op
  // RUN   | one restoring step per cycle, r_cnt 0..31
  // DONE  | quotient/remainder ready; HI/LO written at the closing edge
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [31:0] r_a_raw;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_dbz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_div;
  logic        w_signed;
  logic        w_stall;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_is_div = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_DIVU);
  assign w_signed = (mdu_op_i == OP_DIV);
  assign w_stall  = w_is_div && (r_state != S_DONE) && !mdu_flush_i;

  assign w_mag_a = (w_signed && mdu_a_i[31]) ? (32'd0 - mdu_a_i) : mdu_a_i;
  assign w_mag_b = (w_signed && mdu_b_i[31]) ? (32'd0 - mdu_b_i) : mdu_b_i;

  // Dividend bits shift out of r_quo into the partial remainder as quotient bits shift in.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[31:0] - r_dvs;

  assign w_quo_fix = r_q_neg ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix = r_r_neg ? (32'd0 - r_rem) : r_rem;

  assign w_prod_s = {{32{mdu_a_i[31]}}, mdu_a_i} * {{32{mdu_b_i[31]}}, mdu_b_i};
  assign w_prod_u = {32'd0, mdu_a_i} * {32'd0, mdu_b_i};

  always_comb begin
    mdu_result_o = 32'd0;
    case (mdu_op_i)
      OP_MUL:  mdu_result_o = w_prod_s[31:0];
      OP_MFHI: mdu_result_o = r_hi;
      OP_MFLO: mdu_result_o = r_lo;
      default: mdu_result_o = 32'd0;
    endcase
  end

  assign mdu_stall_o = w_stall;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_dvs   <= 32'd0;
      r_a_raw <= 32'd0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div && !mdu_flush_i) begin
            r_quo   <= w_mag_a;
            r_rem   <= 32'd0;
            r_dvs   <= w_mag_b;
            r_a_raw <= mdu_a_i;
            r_q_neg <= w_signed && (mdu_a_i[31] ^ mdu_b_i[31]);
            r_r_neg <= w_signed && mdu_a_i[31];
            r_dbz   <= (mdu_b_i == 32'd0);
            r_cnt   <= 5'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (mdu_flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_quo <= {r_quo[30:0], w_ge};
            r_rem <= w_ge ? w_sub : w_shift[31:0];
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (!mdu_flush_i) begin
            // Divide by zero reports the raw dividend, with no sign fix-up.
            r_lo <= r_dbz ? 32'hFFFF_FFFF : w_quo_fix;
            r_hi <= r_dbz ? r_a_raw : w_rem_fix;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (!mdu_flush_i && !w_stall) begin
        case (mdu_op_i)
          OP_MULT:  {r_hi, r_lo} <= w_prod_s;
          OP_MULTU: {r_hi, r_lo} <= w_prod_u;
          OP_MTHI:  r_hi <= mdu_a_i;
          OP_MTLO:  r_lo <= mdu_a_i;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_mdu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] result;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdu_op_i     (op),
    .mdu_a_i      (a),
    .mdu_b_i      (b),
    .mdu_flush_i  (flush),
    .mdu_result_o (result),
    .mdu_stall_o  (stall),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  localparam int SEL_HI = 0, SEL_LO = 1, SEL_RES = 2, SEL_STALL = 3;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      case (e.sel)
        SEL_HI:  act = hi;
        SEL_LO:  act = lo;
        SEL_RES: act = result;
        default: act = {31'd0, stall};
      endcase
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale expectation cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s cycle %0d got %h expected %h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv;
  endtask

  // Full divide: 33 stall cycles, DONE with stall low, HI/LO visible the cycle after.
  task automatic run_div(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string n);
    int c;
    c = cyc;
    drive(o, av, bv);
    for (int i = 0; i < 33; i++) expect_at(c + i, SEL_STALL, 32'd1, {n, "_stall_hi"});
    expect_at(c + 33, SEL_STALL, 32'd0, {n, "_stall_done"});
    step(5);
    a = 32'h5A5A_A5A5; b = 32'h0000_0003;
    step(28);
    step(1);
    drive(4'd0, 32'd0, 32'd0);
    expect_at(c + 34, SEL_LO, exp_lo, {n, "_lo"});
    expect_at(c + 34, SEL_HI, exp_hi, {n, "_hi"});
    expect_at(c + 34, SEL_STALL, 32'd0, {n, "_stall_after"});
    step(1);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; flush = 1'b0;
    drive(4'd0, 32'd0, 32'd0);
    step(2);
    expect_at(cyc, SEL_HI, 32'd0, "rst_hi");
    expect_at(cyc, SEL_LO, 32'd0, "rst_lo");
    expect_at(cyc, SEL_STALL, 32'd0, "rst_stall");
    expect_at(cyc, SEL_RES, 32'd0, "rst_result");
    step(1);
    rst_n = 1'b1;
    step(1);

    // MULT / MULTU
    c = cyc;
    drive(4'd4, 32'hFFFF_FFFF, 32'd2);
    expect_at(c, SEL_STALL, 32'd0, "mult_stall");
    step(1);
    drive(4'd5, 32'hFFFF_FFFF, 32'd2);
    expect_at(c + 1, SEL_HI, 32'hFFFF_FFFF, "mult_hi");
    expect_at(c + 1, SEL_LO, 32'hFFFF_FFFE, "mult_lo");
    expect_at(c + 1, SEL_STALL, 32'd0, "multu_stall");
    step(1);
    drive(4'd0, 32'd0, 32'd0);
    expect_at(c + 2, SEL_HI, 32'h0000_0001, "multu_hi");
    expect_at(c + 2, SEL_LO, 32'hFFFF_FFFE, "multu_lo");
    step(1);

    // Moves, MF* reads, MUL leaves HI/LO alone
    c = cyc;
    drive(4'd8, 32'hCAFE_BABE, 32'd0);
    step(1);
    drive(4'd9, 32'h0BAD_F00D, 32'd0);
    expect_at(c + 1, SEL_RES, 32'd0, "mtlo_result");
    step(1);
    drive(4'd6, 32'd0, 32'd0);
    expect_at(c + 2, SEL_RES, 32'hCAFE_BABE, "mfhi");
    step(1);
    drive(4'd7, 32'd0, 32'd0);
    expect_at(c + 3, SEL_RES, 32'h0BAD_F00D, "mflo");
    step(1);
    drive(4'd3, 32'hFFFF_FFFD, 32'd5);
    expect_at(c + 4, SEL_RES, 32'hFFFF_FFF1, "mul_result");
    step(1);
    drive(4'd0, 32'd0, 32'd0);
    expect_at(c + 5, SEL_HI, 32'hCAFE_BABE, "mul_keeps_hi");
    expect_at(c + 5, SEL_LO, 32'h0BAD_F00D, "mul_keeps_lo");
    expect_at(c + 5, SEL_RES, 32'd0, "op0_result");
    step(1);

    // Flush suppresses a MULT write
    c = cyc;
    drive(4'd4, 32'd3, 32'd3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    drive(4'd0, 32'd0, 32'd0);
    expect_at(c + 1, SEL_HI, 32'hCAFE_BABE, "flush_mult_hi");
    expect_at(c + 1, SEL_LO, 32'h0BAD_F00D, "flush_mult_lo");
    step(1);

    // Divides
    run_div(4'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
    run_div(4'd2, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
    run_div(4'd2, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "divu_by0");
    run_div(4'd1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "div_neg_by0");
    run_div(4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_ovf");
    run_div(4'd1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div_7_m2");

    // Flush in RUN cycle 10
    drive(4'd8, 32'h1111_1111, 32'd0);
    step(1);
    drive(4'd9, 32'h1111_1111, 32'd0);
    step(1);
    c = cyc;
    drive(4'd1, 32'd50, 32'd5);
    step(11);
    flush = 1'b1;
    expect_at(c + 11, SEL_STALL, 32'd0, "flush_stall_low");
    step(1);
    flush = 1'b0;
    drive(4'd0, 32'd0, 32'd0);
    expect_at(c + 12, SEL_HI, 32'h1111_1111, "flush_div_hi");
    expect_at(c + 12, SEL_LO, 32'h1111_1111, "flush_div_lo");
    step(1);
    run_div(4'd1, 32'd20, 32'd6, 32'd3, 32'd2, "div_after_flush");

    // Reset during RUN cycle 20
    c = cyc;
    drive(4'd1, 32'd100, 32'd7);
    step(21);
    rst_n = 1'b0;
    drive(4'd0, 32'd0, 32'd0);
    expect_at(c + 21, SEL_HI, 32'd0, "midrst_hi");
    expect_at(c + 21, SEL_LO, 32'd0, "midrst_lo");
    expect_at(c + 21, SEL_STALL, 32'd0, "midrst_stall");
    step(1);
    rst_n = 1'b1;
    step(1);
    run_div(4'd1, 32'd9, 32'd3, 32'd3, 32'd0, "div_9_3");

    for (int i = 0; i < 10 && q.size() > 0; i++) step(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left unchecked, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
